// File: rtl/jk_bank_sequencer.sv
// JK flip-flop bank sequencer.
// jk_ff: one bank element with an active-high asynchronous reset.
// jk_bank_sequencer: accepts HOLD/CLEAR/SET/TOGGLE commands with a bit mask and
// a repeat count, drives the bank's j/k for that many edges, tracks a shadow
// copy of the expected bank state and reports per-command pass/fail plus a
// saturating mismatch count.

module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_bank_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] bank_q,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] q_snap,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic             accept;
  logic             last_edge;
  logic             diff;

  assign accept    = cmd_valid && cmd_ready;
  assign last_edge = (state == APPLY) && (cnt == CNT_W'(1));
  assign diff      = (bank_q != shadow);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = APPLY;
      APPLY:   if (last_edge) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ready purely from state, so it also reads 1 during reset.
  always_comb begin
    cmd_ready = (state == IDLE);
  end

  // Latch the accepted command for the shadow model.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r   <= '0;
      mask_r <= '0;
    end else if (accept) begin
      op_r   <= cmd_op;
      mask_r <= cmd_mask;
    end
  end

  // Remaining-edge counter; a requested count of 0 behaves as 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cmd_count == '0) ? CNT_W'(1) : cmd_count;
    end else if (state == APPLY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Registered j/k drive: loaded on accept, held through APPLY, zero elsewhere.
  // Clearing on the last APPLY edge means the bank sees exactly cnt active edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jk_j <= '0;
      jk_k <= '0;
    end else if (accept) begin
      jk_j <= cmd_op[1] ? cmd_mask : '0;
      jk_k <= cmd_op[0] ? cmd_mask : '0;
    end else if ((state != APPLY) || last_edge) begin
      jk_j <= '0;
      jk_k <= '0;
    end
  end

  // Shadow next value with the same JK semantics on masked bits.
  always_comb begin
    shadow_nxt = shadow;
    unique case (op_r)
      OP_CLEAR:  shadow_nxt = shadow & ~mask_r;
      OP_SET:    shadow_nxt = shadow | mask_r;
      OP_TOGGLE: shadow_nxt = shadow ^ mask_r;
      default:   shadow_nxt = shadow;
    endcase
  end

  // Shadow advances on every edge the bank is driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               shadow <= '0;
    else if (state == APPLY)  shadow <= shadow_nxt;
  end

  // Result capture at the CHECK closing edge; mismatch/q_snap hold until next done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      mismatch  <= 1'b0;
      q_snap    <= '0;
      err_count <= '0;
    end else begin
      done <= (state == CHECK);
      if (state == CHECK) begin
        mismatch <= diff;
        q_snap   <= bank_q;
        if (diff && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
